// File: rtl/mole_autoplayer.sv
// rtl/mole_autoplayer.sv - closed-loop whack-a-mole player driving the game's buttons from its 7-segment bus
// Optional MOLE_MISS_INJECT_EN: every 4th mole press hits the neighbouring segment to exercise wrong-hit lockout.
module mole_autoplayer #(
  parameter int STABLE_CYCLES  = 4,
  parameter int REACT_CYCLES   = 16,
  parameter int PRESS_CYCLES   = 8,
  parameter int RELEASE_CYCLES = 8,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [6:0] seg_in,
  input  logic       dp_in,
  input  logic       start_req,
  output logic [7:0] btn_out,
  output logic       busy,
  output logic [7:0] hits,
  output logic [3:0] score_seen,
  output logic       score_valid
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_OBSERVE,
    S_REACT,
    S_PRESS,
    S_RELEASE,
    S_GAMEOVER,
    S_START
  } state_t;

  localparam logic [CNT_W-1:0] STAB_MAX  = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] REACT_END = CNT_W'(REACT_CYCLES - 1);
  localparam logic [CNT_W-1:0] PRESS_END = CNT_W'(PRESS_CYCLES - 1);
  localparam logic [CNT_W-1:0] REL_END   = CNT_W'(RELEASE_CYCLES - 1);

  state_t           state;
  logic [7:0]       prev_pat;
  logic [CNT_W-1:0] stab_cnt;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       tgt;
  logic [2:0]       press_bit;

  logic [7:0] pat;
  logic       changed;
  logic       stable;
  logic [2:0] zero_cnt;
  logic [2:0] mole_idx;
  logic       mole_valid;
  logic       glyph_hit;
  logic [3:0] glyph_val;
  logic       go_valid;
  logic       start_go;

  assign pat      = {dp_in, seg_in};
  assign changed  = (pat != prev_pat);
  // A pattern flipping on the acceptance cycle must not be decoded with the new value.
  assign stable   = (stab_cnt == STAB_MAX) && !changed;
  assign start_go = start_req && (state == S_IDLE || state == S_GAMEOVER);
  assign busy     = (state != S_IDLE) && (state != S_GAMEOVER);

  always_comb begin
    zero_cnt = 3'd0;
    mole_idx = 3'd0;
    for (int k = 0; k < 7; k++) begin
      if (!seg_in[k]) begin
        zero_cnt = zero_cnt + 3'd1;
        mole_idx = 3'(k);
      end
    end
  end

  assign mole_valid = dp_in && (zero_cnt == 3'd1);

  always_comb begin
    glyph_hit = 1'b1;
    glyph_val = 4'h0;
    case (seg_in)
      7'b1000000: glyph_val = 4'h0;
      7'b1111001: glyph_val = 4'h1;
      7'b0100100: glyph_val = 4'h2;
      7'b0110000: glyph_val = 4'h3;
      7'b0011001: glyph_val = 4'h4;
      7'b0010010: glyph_val = 4'h5;
      7'b0000010: glyph_val = 4'h6;
      7'b1111000: glyph_val = 4'h7;
      7'b0000000: glyph_val = 4'h8;
      7'b0010000: glyph_val = 4'h9;
      7'b0001000: glyph_val = 4'hA;
      7'b0000011: glyph_val = 4'hB;
      7'b1000110: glyph_val = 4'hC;
      7'b0100001: glyph_val = 4'hD;
      7'b0000110: glyph_val = 4'hE;
      7'b0001110: glyph_val = 4'hF;
      default:    glyph_hit = 1'b0;
    endcase
  end

  assign go_valid = !dp_in && glyph_hit;

`ifdef MOLE_MISS_INJECT_EN
  logic [1:0] press_num;

  always_comb begin
    press_bit = tgt;
    if (press_num == 2'd3) press_bit = (tgt == 3'd6) ? 3'd0 : tgt + 3'd1;
  end
`else
  always_comb begin
    press_bit = tgt;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      prev_pat    <= 8'd0;
      stab_cnt    <= '0;
      cnt         <= '0;
      tgt         <= 3'd0;
      btn_out     <= 8'd0;
      hits        <= 8'd0;
      score_seen  <= 4'h0;
      score_valid <= 1'b0;
`ifdef MOLE_MISS_INJECT_EN
      press_num   <= 2'd0;
`endif
    end else begin
      prev_pat <= pat;
      if (changed) stab_cnt <= '0;
      else if (stab_cnt != STAB_MAX) stab_cnt <= stab_cnt + 1'b1;

      if (start_go) begin
        state       <= S_START;
        cnt         <= '0;
        btn_out     <= 8'h01;
        hits        <= 8'd0;
        score_valid <= 1'b0;
`ifdef MOLE_MISS_INJECT_EN
        press_num   <= 2'd0;
`endif
      end else begin
        case (state)
          S_IDLE: begin
            btn_out <= 8'd0;
            if (enable) state <= S_OBSERVE;
          end
          S_OBSERVE: begin
            btn_out <= 8'd0;
            if (!enable) begin
              state <= S_IDLE;
            end else if (stable && mole_valid) begin
              tgt   <= mole_idx;
              cnt   <= '0;
              state <= S_REACT;
            end else if (stable && go_valid) begin
              score_seen  <= glyph_val;
              score_valid <= 1'b1;
              state       <= S_GAMEOVER;
            end
          end
          S_REACT: begin
            if (changed) begin
              state <= S_OBSERVE;
            end else if (cnt == REACT_END) begin
              cnt     <= '0;
              btn_out <= 8'd1 << press_bit;
              hits    <= hits + 8'd1;
`ifdef MOLE_MISS_INJECT_EN
              press_num <= press_num + 2'd1;
`endif
              state   <= S_PRESS;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_PRESS, S_START: begin
            if (cnt == PRESS_END) begin
              cnt     <= '0;
              btn_out <= 8'd0;
              state   <= S_RELEASE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_RELEASE: begin
            btn_out <= 8'd0;
            if (cnt == REL_END) begin
              cnt   <= '0;
              state <= enable ? S_OBSERVE : S_IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          S_GAMEOVER: begin
            btn_out <= 8'd0;
            if (dp_in) begin
              score_valid <= 1'b0;
              state       <= S_OBSERVE;
            end
          end
          default: begin
            btn_out <= 8'd0;
            state   <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/mole_autoplayer.md
Name: mole_autoplayer

Overview:
- Automated player for the whack-a-mole game. It sits on the game's output side and closes the loop back to the button inputs.
- Observes the 7-segment bus (seg, dp) driven by the game and decodes which mole segment is lit.
- After a programmable reaction delay, presses the matching button long enough to pass the game's button debouncers, then releases it.
- Detects game over (dp low), decodes the displayed hex score digit, and on request presses the start button to begin a new game. Used for on-chip demo mode and for self-test.

Parameters:
- STABLE_CYCLES, 4: cycles a display pattern must be unchanged before it is accepted.
- REACT_CYCLES, 16: cycles from pattern acceptance to button press (models reaction time).
- PRESS_CYCLES, 8: cycles a button is held high; must exceed the game debouncer depth of 4.
- RELEASE_CYCLES, 8: cycles all buttons are held low after a press, before observing again.
- CNT_W, 16: width of the internal delay counter; every *_CYCLES value must be below 2^CNT_W.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- enable  in  1  1 = autoplay active; 0 = finish the current press/release, then idle
- seg_in  in  7  game segment bus, active-low, bit k = segment k
- dp_in  in  1  game decimal point; 1 = playing, 0 = game over
- start_req  in  1  single-cycle request to press start (button 0) when idle or in game over
- btn_out  out  8  button drive toward the game inputs, active-high
- busy  out  1  high in any state other than IDLE and GAMEOVER
- hits  out  8  count of mole presses issued since reset or since the last start press; wraps 255 -> 0
- score_seen  out  4  hex digit decoded at game over
- score_valid  out  1  high while in GAMEOVER with a valid digit decoded; clears on any start press

Behaviour:
- Reset (rst_n low at a clk edge, synchronous): state = IDLE, btn_out = 0, hits = 0, score_seen = 0, score_valid = 0, busy = 0, all counters 0.
- A mole pattern is valid when dp_in = 1 and seg_in has exactly one 0 bit. The segment index is the position of that 0 bit (0..6).
- A game-over pattern is dp_in = 0 with seg_in matching one of the 16 hex glyphs: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, B=0000011, C=1000110, D=0100001, E=0000110, F=0001110.
- Stability counter: reset to 0 whenever {dp_in, seg_in} differs from the previous cycle's value; otherwise increments, saturating at STABLE_CYCLES.

States:
- IDLE:
  - btn_out = 0.
  - If start_req: go to START.
  - Else if enable: go to OBSERVE.
- OBSERVE:
  - btn_out = 0.
  - Once the pattern has been stable for STABLE_CYCLES:
    - valid mole: latch the segment index into tgt, go to REACT;
    - game-over glyph: latch score_seen, set score_valid, go to GAMEOVER;
    - any other pattern: stay in OBSERVE.
  - If enable is low: return to IDLE.
- REACT:
  - Counts REACT_CYCLES.
  - If the pattern changes before the count completes: return to OBSERVE with no press.
  - On completion: go to PRESS.
- PRESS:
  - btn_out = 1 << tgt for exactly PRESS_CYCLES cycles.
  - hits increments once, on the first cycle of PRESS.
  - Then go to RELEASE.
- RELEASE:
  - btn_out = 0 for RELEASE_CYCLES cycles.
  - Then go to OBSERVE if enable is high, else IDLE.
  - A repeated mole on the same segment is therefore pressed again only after the full release time.
- GAMEOVER:
  - btn_out = 0.
  - If start_req: go to START.
  - If dp_in returns to 1 (external restart): clear score_valid, go to OBSERVE.
- START:
  - btn_out = 8'h01 for PRESS_CYCLES cycles.
  - Clears score_valid and hits on entry.
  - Then go to RELEASE.

Boundary and priority rules:
- start_req arriving in any state other than IDLE or GAMEOVER is ignored (not queued).
- enable falling during PRESS or RELEASE does not truncate the cycle in progress.
- Reset asserted mid-press drops btn_out to 0 on the same clk edge.
- At most one btn_out bit is high in any cycle.
- btn_out is registered: the first high cycle is the cycle after the state transition into PRESS or START.

Optional Feature:
- Macro: MOLE_MISS_INJECT_EN.
- When defined: every 4th mole press targets segment (tgt+1) mod 7 instead of tgt, to exercise the game's wrong-hit lockout. A 2-bit press counter, reset to 0 and cleared by START, selects which presses are redirected. hits still increments on redirected presses.
- When undefined: always press tgt; no press counter is built.

Test Plan:
- Mole on segment 3: seg_in=1110111, dp_in=1, enable=1 held → btn_out=8'h08 for 8 cycles, first high cycle at 4+16+3 (±1) after the pattern appears; hits=1; then 8 cycles of btn_out=0.
- Glitch: pattern changes to segment 5 during REACT → no press of bit 3; btn_out=8'h20 after a fresh stable period plus reaction delay.
- Game over: dp_in=0, seg_in=0010010 → score_valid=1, score_seen=4'h5, btn_out=0. Then pulse start_req → btn_out=8'h01 for 8 cycles, score_valid=0, hits=0.
- Invalid pattern: seg_in=1100111 with dp_in=1, or seg_in=1111111 → stays in OBSERVE, no btn_out activity for 100 cycles.
- Reset during PRESS: rst_n low for one cycle → btn_out=0, hits=0, state IDLE on the next cycle.
- With MOLE_MISS_INJECT_EN defined: four consecutive moles on segment 6 → presses 0x40, 0x40, 0x40, then 0x01; hits=4.
